prga: RTL and testbench
=======================

// Module: prga
// PURPOSE
//  ARC4 pseudo-random generation + decrypt stage: consumer (reader) of the S memory that ksa
//  leaves behind. Reads length-prefixed ciphertext from CT memory, walks/swaps S, writes
//  length-prefixed plaintext to PT memory. Sits after init/ksa in the arc4 top; all three
//  memories are single-port altsyncram, 8-bit address/data, registered address.
// PARAMETERS
//  RD_LAT   1   memory read latency in cycles (addr sampled at edge N, rddata valid after edge N+RD_LAT)
// PORTS
//  clk        in   1  system clock (CLOCK_50 domain)
//  rst_n      in   1  asynchronous, active-low reset
//  en         in   1  start request; honoured only while rdy=1
//  rdy        out  1  1 = idle, may accept en
//  s_addr     out  8  S memory address
//  s_rddata   in   8  S memory read data
//  s_wrdata   out  8  S memory write data
//  s_wren     out  1  S memory write enable
//  ct_addr    out  8  ciphertext memory address (read only)
//  ct_rddata  in   8  ciphertext read data
//  pt_addr    out  8  plaintext memory address
//  pt_rddata  in   8  plaintext read data (unused, kept for memory symmetry)
//  pt_wrdata  out  8  plaintext write data
//  pt_wren    out  1  plaintext write enable
// BEHAVIOUR
//  - Reset (async, any state): FSM->IDLE, rdy=1, all addr/wrdata=0, s_wren=pt_wren=0; i,j,k,len=0.
//  - Handshake: en sampled on rising edge with rdy=1 -> rdy=0 next cycle; en ignored while rdy=0.
//    rdy returns to 1 only after final pt write has been issued; en held high restarts immediately.
//  - Algorithm (all arithmetic 8-bit, natural mod-256 wrap):
//    len=ct[0]; pt[0]=len; i=0; j=0;
//    for k=1..len: i=i+1; si=s[i]; j=j+si; sj=s[j]; s[i]=sj; s[j]=si;
//                  pt[k]=s[si+sj] ^ ct[k].
//  - States: IDLE, RD_LEN, WR_LEN, RD_SI, RD_SJ, WR_SI, WR_SJ, RD_PAD (ct[k] read in parallel,
//    separate memory), WR_PT, DONE. Each RD_* state waits RD_LAT cycles then captures rddata.
//  - si, sj captured into registers before either swap write; i==j case must leave S unchanged.
//  - At most one write enable per memory per cycle; wren is high for exactly one cycle per write.
//  - Per-byte cost constant, <=10 cycles at RD_LAT=1; total en->rdy <= 10*len+8 cycles.
//  - len=0: only pt[0]=0 written, no S access, no other PT writes.
//  - Never writes pt[k] for k>len; never writes CT. len=255: j wraps repeatedly, i reaches 255.
//  - rst_n deasserted mid-message: stop immediately, no further writes; S/PT contents partial,
//    not restored. Next en starts a fresh message from current S.
// TESTING
//  1 Identity S (s[x]=x), ct={03,AA,BB,CC} -> pt={03,A8,BE,CB} (pads 02,05,07); S afterwards
//    s[2]=03,s[3]=05,s[5]=02, all others identity (covers i==j at k=1).
//  2 ct[0]=00 -> pt[0]=00 only, s_wren never asserted, rdy back to 1 within 8 cycles.
//  3 Pulse en again 3 cycles after start -> ignored; exactly one run, pt identical to test 1.
//  4 Drop rst_n during k=2 -> rdy=1 and all wren=0 in the same cycle; pt[3] never written.
//  5 After ksa with key 24'h00033C and reference ct, len=255 -> pt matches software ARC4 model
//    byte-for-byte; no write to pt addresses outside 0..255 beyond len.
//  6 en held high across two runs on identity S -> second run decrypts with post-run-1 S,
//    matches model chained state.

Source files
------------

// File: rtl/prga.sv
// ARC4 pseudo-random generation and decrypt stage: walks and swaps the S memory left by
// ksa, XORs the keystream with length-prefixed ciphertext and writes length-prefixed plaintext.
module prga #(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren,
  output logic [3:0] dbg_state
);

  // Handshake: en is taken on a rising edge only while rdy=1; rdy drops the next cycle and
  // rises again once the final plaintext write has been issued. en is ignored while rdy=0.
  typedef enum logic [3:0] {
    S_IDLE, S_RD_LEN, S_WR_LEN, S_RD_SI, S_RD_SJ,
    S_WR_SI, S_WR_SJ, S_RD_PAD, S_WR_PT, S_DONE
  } state_t;

  localparam logic [3:0] LAT = 4'(RD_LAT);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [7:0] r_i, r_j, r_k, r_len, r_si, r_sj;
  logic       r_rdy, r_s_wren, r_pt_wren;
  logic [7:0] r_s_addr, r_s_wrdata, r_ct_addr, r_pt_addr, r_pt_wrdata;

  logic       w_rd_ok;
  logic [7:0] w_i_nx, w_j_nx, w_pad_addr;
  logic       w_unused_pt;

  assign w_rd_ok     = (r_cnt == LAT);
  assign w_i_nx      = r_i + 8'd1;
  assign w_j_nx      = r_j + s_rddata;
  assign w_pad_addr  = r_si + r_sj;
  assign w_unused_pt = ^pt_rddata;

  // Address/enable registers are loaded on entry to a state; a read state then holds
  // for RD_LAT+1 cycles so the memory's own address register and output settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_i         <= 8'd0;
      r_j         <= 8'd0;
      r_k         <= 8'd0;
      r_len       <= 8'd0;
      r_si        <= 8'd0;
      r_sj        <= 8'd0;
      r_rdy       <= 1'b1;
      r_s_wren    <= 1'b0;
      r_pt_wren   <= 1'b0;
      r_s_addr    <= 8'd0;
      r_s_wrdata  <= 8'd0;
      r_ct_addr   <= 8'd0;
      r_pt_addr   <= 8'd0;
      r_pt_wrdata <= 8'd0;
    end else begin
      r_s_wren  <= 1'b0;
      r_pt_wren <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_rdy     <= 1'b0;
            r_ct_addr <= 8'd0;
            r_cnt     <= 4'd0;
            r_i       <= 8'd0;
            r_j       <= 8'd0;
            r_k       <= 8'd0;
            r_state   <= S_RD_LEN;
          end
        end
        S_RD_LEN: begin
          if (w_rd_ok) begin
            r_len       <= ct_rddata;
            r_pt_addr   <= 8'd0;
            r_pt_wrdata <= ct_rddata;
            r_pt_wren   <= 1'b1;
            r_state     <= S_WR_LEN;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WR_LEN: begin
          if (r_len == 8'd0) begin
            r_state <= S_DONE;
          end else begin
            r_k      <= 8'd1;
            r_i      <= w_i_nx;
            r_s_addr <= w_i_nx;
            r_cnt    <= 4'd0;
            r_state  <= S_RD_SI;
          end
        end
        S_RD_SI: begin
          if (w_rd_ok) begin
            r_si     <= s_rddata;
            r_j      <= w_j_nx;
            r_s_addr <= w_j_nx;
            r_cnt    <= 4'd0;
            r_state  <= S_RD_SJ;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RD_SJ: begin
          // Both values are held before the first swap write, so i==j rewrites the same byte.
          if (w_rd_ok) begin
            r_sj       <= s_rddata;
            r_s_addr   <= r_i;
            r_s_wrdata <= s_rddata;
            r_s_wren   <= 1'b1;
            r_state    <= S_WR_SI;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WR_SI: begin
          r_s_addr   <= r_j;
          r_s_wrdata <= r_si;
          r_s_wren   <= 1'b1;
          r_state    <= S_WR_SJ;
        end
        S_WR_SJ: begin
          r_s_addr  <= w_pad_addr;
          r_ct_addr <= r_k;
          r_cnt     <= 4'd0;
          r_state   <= S_RD_PAD;
        end
        S_RD_PAD: begin
          if (w_rd_ok) begin
            r_pt_addr   <= r_k;
            r_pt_wrdata <= s_rddata ^ ct_rddata;
            r_pt_wren   <= 1'b1;
            r_state     <= S_WR_PT;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WR_PT: begin
          if (r_k == r_len) begin
            r_state <= S_DONE;
          end else begin
            r_k      <= r_k + 8'd1;
            r_i      <= w_i_nx;
            r_s_addr <= w_i_nx;
            r_cnt    <= 4'd0;
            r_state  <= S_RD_SI;
          end
        end
        S_DONE: begin
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rdy       = r_rdy;
  assign s_addr    = r_s_addr;
  assign s_wrdata  = r_s_wrdata;
  assign s_wren    = r_s_wren;
  assign ct_addr   = r_ct_addr;
  assign pt_addr   = r_pt_addr;
  assign pt_wrdata = r_pt_wrdata;
  assign pt_wren   = r_pt_wren;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_prga.sv
// Bench for prga: memory models for S/CT/PT, a plain ARC4 reference, and a scoreboard
// that checks every plaintext write against the expected queue.
module tb_prga;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_rddata, pt_wrdata;
  logic       pt_wren;
  logic [3:0] dbg_state;

  logic [7:0]  s_mem[256];
  logic [7:0]  ct_mem[256];
  logic [7:0]  pt_mem[256];
  logic [7:0]  ref_s[256];
  logic [7:0]  msg[256];
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;

  int errors = 0;
  int checks = 0;
  int pt_wr_cnt = 0;
  int s_wr_cnt = 0;

  always #5 clk = ~clk;

  prga #(.RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
    .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .ct_addr(ct_addr), .ct_rddata(ct_rddata),
    .pt_addr(pt_addr), .pt_rddata(pt_rddata), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren),
    .dbg_state(dbg_state)
  );

  // Single-port synchronous memories: registered address, one-cycle read.
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wrdata;
    if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    pt_rddata <= pt_mem[pt_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every PT write must match the head of the expected queue.
  always @(negedge clk) begin
    if (s_wren) s_wr_cnt++;
    if (pt_wren) begin
      pt_wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pt_unexpected: got write addr=0x%0h data=0x%0h, expected none", pt_addr, pt_wrdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pt_write", {16'd0, pt_addr, pt_wrdata}, {16'd0, mon_e});
      end
    end
  end

  // Reference ARC4 keystream over ref_s; processes at most 'limit' bytes of msg.
  task automatic model_run(input int limit);
    int len, i, j;
    logic [7:0] t;
    len = msg[0];
    i = 0;
    j = 0;
    exp_q.push_back({8'd0, msg[0]});
    for (int k = 1; k <= len && k <= limit; k++) begin
      i = (i + 1) & 255;
      j = (j + ref_s[i]) & 255;
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
      exp_q.push_back({8'(k), ref_s[(ref_s[i] + ref_s[j]) & 255] ^ msg[k]});
    end
  endtask

  task automatic ref_identity();
    for (int x = 0; x < 256; x++) ref_s[x] = 8'(x);
  endtask

  task automatic ref_ksa(input logic [23:0] key);
    int j;
    logic [7:0] kb[3];
    logic [7:0] t;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    ref_identity();
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + ref_s[i] + kb[i % 3]) & 255;
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  task automatic ref_shuffle();
    int r;
    logic [7:0] t;
    ref_identity();
    for (int x = 255; x > 0; x--) begin
      r = $urandom_range(x, 0);
      t = ref_s[x];
      ref_s[x] = ref_s[r];
      ref_s[r] = t;
    end
  endtask

  task automatic load_s();
    for (int x = 0; x < 256; x++) s_mem[x] <= ref_s[x];
  endtask

  task automatic load_ct();
    for (int x = 0; x < 256; x++) ct_mem[x] <= msg[x];
  endtask

  task automatic fill_pt(input logic [7:0] v);
    for (int x = 0; x < 256; x++) pt_mem[x] <= v;
  endtask

  task automatic rand_msg(input int len);
    for (int x = 0; x < 256; x++) msg[x] = 8'($urandom_range(255, 0));
    msg[0] = 8'(len);
  endtask

  task automatic check_s(input string name);
    int bad;
    bad = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic start_run();
    int n;
    n = 0;
    while (rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int cyc);
    cyc = 1;
    while (rdy !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk(name, rdy, 1);
  endtask

  task automatic set_test1_msg();
    for (int x = 0; x < 256; x++) msg[x] = 8'h00;
    msg[0] = 8'h03;
    msg[1] = 8'hAA;
    msg[2] = 8'hBB;
    msg[3] = 8'hCC;
  endtask

  task automatic check_test1_pt(input string name);
    chk({name, "_pt0"}, pt_mem[0], 8'h03);
    chk({name, "_pt1"}, pt_mem[1], 8'hA8);
    chk({name, "_pt2"}, pt_mem[2], 8'hBE);
    chk({name, "_pt3"}, pt_mem[3], 8'hCB);
  endtask

  initial begin
    int cyc, n0, s0, gap, n;
    logic hit;
    rst_n = 1'b0;
    en    = 1'b0;
    ref_identity();
    load_s();
    set_test1_msg();
    load_ct();
    fill_pt(8'h00);
    #12;
    chk("reset_rdy", rdy, 1);
    chk("reset_s_wren", s_wren, 0);
    chk("reset_pt_wren", pt_wren, 0);
    chk("reset_s_addr", s_addr, 0);
    chk("reset_ct_addr", ct_addr, 0);
    chk("reset_pt_addr", pt_addr, 0);
    chk("reset_wrdata", {s_wrdata, pt_wrdata}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: identity S, known vector.
    model_run(256);
    start_run();
    wait_done("t1_done", 200, cyc);
    check_test1_pt("t1");
    chk("t1_s2", s_mem[2], 8'h03);
    chk("t1_s3", s_mem[3], 8'h05);
    chk("t1_s5", s_mem[5], 8'h02);
    check_s("t1_s_all");

    // Test 2: zero-length message.
    for (int x = 0; x < 256; x++) msg[x] = 8'h5A;
    msg[0] = 8'h00;
    load_ct();
    s0 = s_wr_cnt;
    n0 = pt_wr_cnt;
    model_run(256);
    start_run();
    wait_done("t2_done", 20, cyc);
    chk("t2_cycles_le8", cyc <= 8, 1);
    chk("t2_no_s_wren", s_wr_cnt - s0, 0);
    chk("t2_pt_writes", pt_wr_cnt - n0, 1);
    chk("t2_pt0", pt_mem[0], 8'h00);

    // Test 3: en re-pulsed while busy is ignored.
    ref_identity();
    load_s();
    set_test1_msg();
    load_ct();
    fill_pt(8'h00);
    n0 = pt_wr_cnt;
    model_run(256);
    start_run();
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_done("t3_done", 200, cyc);
    repeat (40) @(negedge clk);
    chk("t3_pt_writes", pt_wr_cnt - n0, 4);
    chk("t3_rdy_idle", rdy, 1);
    check_test1_pt("t3");

    // Test 4: reset during byte k=2.
    ref_shuffle();
    load_s();
    rand_msg(6);
    load_ct();
    fill_pt(8'hEE);
    model_run(1);
    start_run();
    hit = 1'b0;
    n = 0;
    while (!hit && n < 100) begin
      @(negedge clk);
      hit = pt_wren && (pt_addr == 8'd1);
      n++;
    end
    chk("t4_saw_pt1", hit, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_rdy", rdy, 1);
    chk("t4_rst_wren", {s_wren, pt_wren}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t4_queue_drained", exp_q.size(), 0);
    chk("t4_pt2_untouched", pt_mem[2], 8'hEE);
    chk("t4_pt3_untouched", pt_mem[3], 8'hEE);
    check_s("t4_s_partial");
    // Fresh message continues from the partially swapped S.
    rand_msg(9);
    load_ct();
    model_run(256);
    start_run();
    wait_done("t4b_done", 200, cyc);
    check_s("t4b_s");

    // Test 5: ksa key 00033C, full 255-byte message.
    ref_ksa(24'h00033C);
    load_s();
    rand_msg(255);
    load_ct();
    fill_pt(8'h00);
    model_run(256);
    start_run();
    wait_done("t5_done", 3000, cyc);
    chk("t5_cycles", cyc <= 10 * 255 + 8, 1);
    check_s("t5_s");

    // Test 6: en held high across two back-to-back runs.
    ref_identity();
    load_s();
    rand_msg(5);
    load_ct();
    n0 = pt_wr_cnt;
    model_run(256);
    model_run(256);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    n = 0;
    while (rdy !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    gap = 0;
    while (rdy === 1'b1 && gap < 10) begin
      @(negedge clk);
      gap++;
    end
    en = 1'b0;
    chk("t6_restart_gap", gap, 1);
    wait_done("t6_done", 200, cyc);
    repeat (20) @(negedge clk);
    chk("t6_pt_writes", pt_wr_cnt - n0, 12);
    check_s("t6_s_chained");

    // Random permutations and lengths.
    for (int r = 0; r < 4; r++) begin
      ref_shuffle();
      load_s();
      rand_msg($urandom_range(40, 1));
      load_ct();
      model_run(256);
      start_run();
      wait_done("rand_done", 600, cyc);
      check_s("rand_s");
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
